seven_segment_scan_controller: RTL and testbench
================================================

# seven_segment_scan_controller

Time-multiplexed scan controller for a bank of common-anode seven-segment digits sharing one `seven_segment_display` decoder. It holds a frame-buffered copy of N BCD digits and decimal points and walks one active-low anode at a time. Each digit slot has a guard interval to suppress ghosting. Display updates use a request/acknowledge handshake and take effect only on frame boundaries, so a half-updated number is never shown. It sits between the integer-to-BCD logic and the decoder/pins.

## Interface
Parameters:
- `N_DIGITS`, 4: number of digits; legal range 1..8.
- `REFRESH_DIV`, 50000: clock cycles per digit slot; must be ≥ `GUARD_CYCLES`+2.
- `GUARD_CYCLES`, 500: cycles at the start of each slot with all anodes off.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `digits`, in, 4*N_DIGITS: BCD digits; `[3:0]` is the least-significant digit (slot 0).
- `dps`, in, N_DIGITS: decimal points, active-low (0 = lit); bit i belongs to slot i.
- `update`, in, 1: single-cycle request to capture `digits`/`dps`.
- `update_ack`, out, 1: one-cycle pulse when the captured value becomes visible.
- `digit_to_be_displayed`, out, 4: code sent to the decoder; 4'hF means blank.
- `dp`, out, 1: decimal point sent to the decoder, active-low.
- `anode`, out, N_DIGITS: digit enables, active-low; at most one bit is 0.

## Operation
- Counters:
  - `tick`: 0..REFRESH_DIV-1, increments every cycle.
  - `idx`: 0..N_DIGITS-1, increments when `tick` wraps; wraps N_DIGITS-1 → 0.
- Frame boundary: the clock edge where `tick`=REFRESH_DIV-1 and `idx`=N_DIGITS-1.
- Slot phases, each one cycle after the counter state is reached:
  - GUARD (`tick` < GUARD_CYCLES): `anode` = all 1s.
  - ON (`tick` ≥ GUARD_CYCLES): `anode[idx]` = 0.
  - `digit_to_be_displayed` and `dp` take slot `idx` values at slot start and hold them for the whole slot.
- Buffering:
  - `update`=1 writes the staging register and sets `pending`.
  - A later `update` before the boundary overwrites staging; the last write wins.
  - At the boundary with `pending`=1: staging → shadow, `pending` cleared, `update_ack`=1 for one cycle.
  - `update` coincident with the boundary: the input values bypass straight into shadow, `pending` cleared, `update_ack`=1 that cycle.
  - No pending update at the boundary: shadow unchanged, no ack.
- Digit codes 4'hA–4'hE are passed through unchanged; the decoder blanks them.
- Reset, including mid-frame:
  - `tick`=0, `idx`=0.
  - Shadow digits all 4'hF, shadow dps all 1s, `pending`=0.
  - Outputs: `anode`=all 1s, `digit_to_be_displayed`=4'hF, `dp`=1, `update_ack`=0.
  - A staged update that is pending when reset asserts is discarded.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Update to visible: data is visible in the first ON cycle of slot 0 after the next frame boundary. Worst case is N_DIGITS*REFRESH_DIV + GUARD_CYCLES + 1 cycles.
- `update_ack` is registered and asserts in the cycle after the boundary edge.
- Refresh rate = f_clk / (N_DIGITS*REFRESH_DIV).
- Duty per digit = (REFRESH_DIV − GUARD_CYCLES) / (N_DIGITS*REFRESH_DIV).

## Configuration
- Macro: `SEVEN_SEG_LEADING_ZERO_BLANK_EN`.
- Defined:
  - A shadow digit of 0 in slot i > 0 is replaced by 4'hF when every more-significant slot is also 0 or 4'hF.
  - Slot 0 is never blanked.
  - `dp` is unaffected.
  - Blanking is evaluated on the shadow copy, so it changes only at frame boundaries.
- Undefined: shadow digits are displayed verbatim.

## Test plan
All scenarios use N_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2.
- Reset, then free-run one frame:
  - Outputs during reset: `anode`=4'b1111, `digit_to_be_displayed`=4'hF, `dp`=1, `update_ack`=0.
  - After release, each slot gives 2 cycles of 4'b1111 then 6 cycles of the active anode, in the order 1110, 1101, 1011, 0111, then wrapping to 1110.
  - Every slot shows digit 4'hF.
- Mid-frame update, `digits`=16'h1234, `dps`=4'b1110:
  - No output change before the boundary.
  - `update_ack` high for exactly one cycle after the boundary.
  - Slot 0 shows 4 with `dp`=0; slots 1/2/3 show 3/2/1 with `dp`=1.
- Two updates in one frame (16'h1111 then 16'h2222):
  - Only 2222 is displayed.
  - Exactly one `update_ack`.
- Update asserted on the boundary edge with 16'h9876:
  - `update_ack` asserts the next cycle.
  - Slot 0 shows 6 in that frame.
- Reset asserted during the ON phase of slot 2 with an update pending:
  - Next cycle: `anode`=4'b1111, `digit_to_be_displayed`=4'hF.
  - Scan restarts at slot 0.
  - The pending value is never shown and never acknowledged.
- With `SEVEN_SEG_LEADING_ZERO_BLANK_EN`:
  - 16'h0050 displays F, F, 5, 0 (slots 3..0).
  - 16'h0000 displays F, F, F, 0.
  - Without the macro, 16'h0050 displays 0, 0, 5, 0.

Source files
------------

// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed scan controller for common-anode seven-segment digits.
// Holds a frame-buffered (staging -> shadow) copy of the BCD digits and
// decimal points and walks one active-low anode per slot, with a blanking
// guard interval at the start of every slot.
// Optional feature macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN (leading-zero blanking).
module seven_segment_scan_controller #(
    parameter int unsigned N_DIGITS     = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned GUARD_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   dps,
    input  logic                  update,
    output logic                  update_ack,
    output logic [3:0]            digit_to_be_displayed,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   anode
);

    localparam int unsigned TICK_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned DIG_W  = 4 * N_DIGITS;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_DIV - 1);
    localparam logic [TICK_W-1:0] GUARD_END = TICK_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);

    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DIG_W-1:0]    stage_dig_q, stage_dig_d;
    logic [N_DIGITS-1:0] stage_dp_q, stage_dp_d;
    logic                pending_q, pending_d;
    logic [DIG_W-1:0]    shadow_dig_q, shadow_dig_d;
    logic [N_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic                ack_q, ack_d;
    logic [3:0]          digit_q, digit_d;
    logic                dp_q, dp_d;
    logic [N_DIGITS-1:0] anode_q, anode_d;

    logic                boundary_c;
    logic [3:0]          disp_c [N_DIGITS];
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    logic                higher_blank_c;
`endif

    // Per-slot display codes derived from the shadow copy (optionally leading-zero blanked).
    always_comb begin
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        higher_blank_c = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            disp_c[i] = shadow_dig_q[4*i +: 4];
            if ((i > 0) && higher_blank_c && (shadow_dig_q[4*i +: 4] == 4'h0)) begin
                disp_c[i] = 4'hF;
            end
            higher_blank_c = higher_blank_c &&
                             ((shadow_dig_q[4*i +: 4] == 4'h0) || (shadow_dig_q[4*i +: 4] == 4'hF));
        end
`else
        for (int i = 0; i < N_DIGITS; i++) begin
            disp_c[i] = shadow_dig_q[4*i +: 4];
        end
`endif
    end

    // Next-state: scan counters, staging/shadow buffering and registered outputs.
    always_comb begin
        tick_d       = tick_q;
        idx_d        = idx_q;
        stage_dig_d  = stage_dig_q;
        stage_dp_d   = stage_dp_q;
        pending_d    = pending_q;
        shadow_dig_d = shadow_dig_q;
        shadow_dp_d  = shadow_dp_q;
        ack_d        = 1'b0;
        digit_d      = digit_q;
        dp_d         = dp_q;
        anode_d      = '1;

        boundary_c = (tick_q == TICK_LAST) && (idx_q == IDX_LAST);

        if (tick_q == TICK_LAST) begin
            tick_d = '0;
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            tick_d = tick_q + TICK_W'(1);
        end

        // A request on the boundary edge bypasses staging; otherwise stage it.
        if (boundary_c) begin
            if (update) begin
                shadow_dig_d = digits;
                shadow_dp_d  = dps;
                pending_d    = 1'b0;
                ack_d        = 1'b1;
            end else if (pending_q) begin
                shadow_dig_d = stage_dig_q;
                shadow_dp_d  = stage_dp_q;
                pending_d    = 1'b0;
                ack_d        = 1'b1;
            end
        end else if (update) begin
            stage_dig_d = digits;
            stage_dp_d  = dps;
            pending_d   = 1'b1;
        end

        // Digit and dp latch at slot start and hold for the whole slot.
        if (tick_q == '0) begin
            digit_d = disp_c[idx_q];
            dp_d    = shadow_dp_q[idx_q];
        end

        if (tick_q >= GUARD_END) begin
            anode_d = ~(N_DIGITS'(1) << idx_q);
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q       <= '0;
            idx_q        <= '0;
            stage_dig_q  <= '1;
            stage_dp_q   <= '1;
            pending_q    <= 1'b0;
            shadow_dig_q <= '1;
            shadow_dp_q  <= '1;
            ack_q        <= 1'b0;
            digit_q      <= 4'hF;
            dp_q         <= 1'b1;
            anode_q      <= '1;
        end else begin
            tick_q       <= tick_d;
            idx_q        <= idx_d;
            stage_dig_q  <= stage_dig_d;
            stage_dp_q   <= stage_dp_d;
            pending_q    <= pending_d;
            shadow_dig_q <= shadow_dig_d;
            shadow_dp_q  <= shadow_dp_d;
            ack_q        <= ack_d;
            digit_q      <= digit_d;
            dp_q         <= dp_d;
            anode_q      <= anode_d;
        end
    end

    assign update_ack            = ack_q;
    assign digit_to_be_displayed = digit_q;
    assign dp                    = dp_q;
    assign anode                 = anode_q;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Directed bench for seven_segment_scan_controller (N_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2).
module tb_seven_segment_scan_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  dps;
    logic        update;
    logic        update_ack;
    logic [3:0]  digit_to_be_displayed;
    logic        dp;
    logic [3:0]  anode;

    int n_tests = 0;
    int n_fail  = 0;

    seven_segment_scan_controller #(
        .N_DIGITS    (4),
        .REFRESH_DIV (8),
        .GUARD_CYCLES(2)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .digits               (digits),
        .dps                  (dps),
        .update               (update),
        .update_ack           (update_ack),
        .digit_to_be_displayed(digit_to_be_displayed),
        .dp                   (dp),
        .anode                (anode)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          off_a;
        logic [15:0] val_a;
        logic [3:0]  dp_a;
        int          off_b;
        logic [15:0] val_b;
        logic [3:0]  dp_b;
        logic        exp_ack;
        logic [15:0] exp_dig;
        logic [3:0]  exp_dp;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %h expected %h", name, k, act, exp);
        end
    endtask

    // Outputs sampled now reflect scan state k (0..31) of a frame showing show_d/show_dp.
    task automatic check_cycle(input int k, input logic [15:0] show_d, input logic [3:0] show_dp,
                               input logic exp_ack);
        logic [1:0] slot;
        logic [3:0] one;
        logic [3:0] exp_an;
        slot   = 2'(k / 8);
        one    = 4'b0001;
        exp_an = ((k % 8) < 2) ? 4'b1111 : ~(one << slot);
        chk("anode", k, 32'(anode), 32'(exp_an));
        chk("digit", k, 32'(digit_to_be_displayed), 32'(show_d[4*slot +: 4]));
        chk("dp", k, 32'(dp), 32'(show_dp[slot]));
        chk("ack", k, 32'(update_ack), 32'((k == 31) && exp_ack));
    endtask

    // One full frame; optional update requests raised after sampling offsets off_a/off_b.
    task automatic run_frame(input logic [15:0] show_d, input logic [3:0] show_dp,
                             input int off_a, input logic [15:0] val_a, input logic [3:0] dp_a,
                             input int off_b, input logic [15:0] val_b, input logic [3:0] dp_b,
                             input logic exp_ack);
        for (int k = 0; k < 32; k++) begin
            @(posedge clk);
            #1;
            check_cycle(k, show_d, show_dp, exp_ack);
            if (k == off_a) begin
                update = 1'b1; digits = val_a; dps = dp_a;
            end else if (k == off_b) begin
                update = 1'b1; digits = val_b; dps = dp_b;
            end else begin
                update = 1'b0;
            end
        end
    endtask

    logic [15:0] cur_d;
    logic [3:0]  cur_dp;

    initial begin
        reset  = 1'b1;
        update = 1'b0;
        digits = 16'h0000;
        dps    = 4'b1111;

        //                off  val_a    dp_a     off val_b    dp_b     ack   exp_dig  exp_dp
        vecs[0] = '{10, 16'h1234, 4'b1110, -1, 16'h0000, 4'b1111, 1'b1, 16'h1234, 4'b1110};
        vecs[1] = '{ 5, 16'h1111, 4'b1111, 20, 16'h2222, 4'b1111, 1'b1, 16'h2222, 4'b1111};
        vecs[2] = '{30, 16'h9876, 4'b1111, -1, 16'h0000, 4'b1111, 1'b1, 16'h9876, 4'b1111};
        vecs[3] = '{-1, 16'h0000, 4'b1111, -1, 16'h0000, 4'b1111, 1'b0, 16'h9876, 4'b1111};
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        vecs[4] = '{12, 16'h0050, 4'b1111, -1, 16'h0000, 4'b1111, 1'b1, 16'hFF50, 4'b1111};
        vecs[5] = '{12, 16'h0000, 4'b1111, -1, 16'h0000, 4'b1111, 1'b1, 16'hFFF0, 4'b1111};
        vecs[6] = '{ 3, 16'h0E0A, 4'b0101, -1, 16'h0000, 4'b1111, 1'b1, 16'hFE0A, 4'b0101};
`else
        vecs[4] = '{12, 16'h0050, 4'b1111, -1, 16'h0000, 4'b1111, 1'b1, 16'h0050, 4'b1111};
        vecs[5] = '{12, 16'h0000, 4'b1111, -1, 16'h0000, 4'b1111, 1'b1, 16'h0000, 4'b1111};
        vecs[6] = '{ 3, 16'h0E0A, 4'b0101, -1, 16'h0000, 4'b1111, 1'b1, 16'h0E0A, 4'b0101};
`endif

        // Outputs while reset is held.
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_anode", -1, 32'(anode), 32'hF);
            chk("rst_digit", -1, 32'(digit_to_be_displayed), 32'hF);
            chk("rst_dp", -1, 32'(dp), 32'h1);
            chk("rst_ack", -1, 32'(update_ack), 32'h0);
        end
        reset = 1'b0;

        // Free-running frame of blanks, then the update vectors.
        cur_d  = 16'hFFFF;
        cur_dp = 4'b1111;
        run_frame(cur_d, cur_dp, -1, 16'h0, 4'hF, -1, 16'h0, 4'hF, 1'b0);
        for (int v = 0; v < 7; v++) begin
            run_frame(cur_d, cur_dp, vecs[v].off_a, vecs[v].val_a, vecs[v].dp_a,
                      vecs[v].off_b, vecs[v].val_b, vecs[v].dp_b, vecs[v].exp_ack);
            cur_d  = vecs[v].exp_dig;
            cur_dp = vecs[v].exp_dp;
        end

        // Reset during the ON phase of slot 2 with an update pending.
        for (int k = 0; k <= 20; k++) begin
            @(posedge clk);
            #1;
            check_cycle(k, cur_d, cur_dp, 1'b0);
            update = (k == 5);
            if (k == 5) begin
                digits = 16'h5555; dps = 4'b0000;
            end
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_anode", 20, 32'(anode), 32'hF);
        chk("midrst_digit", 20, 32'(digit_to_be_displayed), 32'hF);
        chk("midrst_dp", 20, 32'(dp), 32'h1);
        chk("midrst_ack", 20, 32'(update_ack), 32'h0);
        reset = 1'b0;

        // Scan restarts at slot 0; the discarded value never appears or acks.
        run_frame(16'hFFFF, 4'b1111, -1, 16'h0, 4'hF, -1, 16'h0, 4'hF, 1'b0);
        run_frame(16'hFFFF, 4'b1111, -1, 16'h0, 4'hF, -1, 16'h0, 4'hF, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
